// File: rtl/pwm_pkg.sv
// Shared definitions for the multi-channel PWM: register offsets, CTRL bits,
// counter direction and the Wishbone byte-select mask helper.
package pwm_pkg;

    localparam logic [7:0] OFF_CTRL     = 8'h00;
    localparam logic [7:0] OFF_PERIOD   = 8'h04;
    localparam logic [7:0] OFF_PRESCALE = 8'h08;
    localparam logic [7:0] OFF_STATUS   = 8'h0C;
    localparam logic [7:0] OFF_POL      = 8'h10;
    localparam logic [7:0] OFF_DUTY0    = 8'h20;

    localparam int DUTY_STRIDE = 4;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_CENTER = 1;
    localparam int CTRL_IE     = 2;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    // Expands the four byte selects into a per-bit write mask.
    function automatic logic [31:0] byte_mask(input logic [3:0] sel);
        logic [31:0] m;
        m = '0;
        for (int b = 0; b < 4; b++) begin
            m[b*8 +: 8] = {8{sel[b]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: shadow and active duty registers, the counter compare and
// the registered, polarity-adjusted output.
module pwm_channel
    import pwm_pkg::*;
#(
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          load_act,
    input  logic          wr_en,
    input  logic [CW-1:0] wr_mask,
    input  logic [CW-1:0] wr_data,
    input  logic [CW-1:0] cnt,
    input  logic          pol,
    output logic [CW-1:0] duty_shadow,
    output logic          pwm
);

    logic [CW-1:0] duty_q, duty_d;
    logic [CW-1:0] duty_act_q, duty_act_d;
    logic          pwm_q, pwm_d;
    logic          raw;

    always_comb begin
        duty_d = duty_q;
        if (wr_en) begin
            duty_d = (duty_q & ~wr_mask) | (wr_data & wr_mask);
        end
        // The active copy changes only with the counter wrap, so no runt pulses.
        duty_act_d = load_act ? duty_q : duty_act_q;
        raw        = (cnt < duty_act_q);
        pwm_d      = en ? (raw ^ pol) : pol;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            duty_q     <= '0;
            duty_act_q <= '0;
            pwm_q      <= 1'b0;
        end else begin
            duty_q     <= duty_d;
            duty_act_q <= duty_act_d;
            pwm_q      <= pwm_d;
        end
    end

    assign duty_shadow = duty_q;
    assign pwm         = pwm_q;

endmodule

// File: rtl/user_proj_pwm_multi.sv
// Multi-channel PWM on the Caravel Wishbone slave port: register file, shared
// prescaler, period counter with direction FSM, STATUS flag and interrupt.
module user_proj_pwm_multi
    import pwm_pkg::*;
#(
    parameter int          NCH      = 8,
    parameter int          CW       = 16,
    parameter logic [31:0] BASE_ADR = 32'h3000_0000
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic            wbs_stb_i,
    input  logic            wbs_cyc_i,
    input  logic            wbs_we_i,
    input  logic [3:0]      wbs_sel_i,
    input  logic [31:0]     wbs_dat_i,
    input  logic [31:0]     wbs_adr_i,
    output logic            wbs_ack_o,
    output logic [31:0]     wbs_dat_o,
    output logic [NCH-1:0]  pwm_o,
    output logic [NCH-1:0]  pwm_oeb,
    output logic            irq_o
);

    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [2:0]     ctrl_q, ctrl_d;
    logic [CW-1:0]  period_q, period_d;
    logic [7:0]     prescale_q, prescale_d;
    logic [NCH-1:0] pol_q, pol_d;
    logic           pf_q, pf_d;
    logic           irq_q, irq_d;
    logic           ack_q, ack_d;
    logic [31:0]    dat_q, dat_d;

    logic [7:0]     pcnt_q, pcnt_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [CW-1:0]  period_act_q, period_act_d;
    dir_e           dir_q, dir_d;

    logic           en, center, ie;
    logic           tick, boundary, load_act;
    logic [7:0]     off;
    logic           hit, req, wr_fire, rd_fire;
    logic [31:0]    wr_mask, rdata;
    logic [NCH-1:0] duty_hit;
    logic [CW-1:0]  duty_sh [NCH];
    logic           unused_bits;

    assign en     = ctrl_q[CTRL_EN];
    assign center = ctrl_q[CTRL_CENTER];
    assign ie     = ctrl_q[CTRL_IE];

    // Bus handshake: a request is stb & cyc inside the 256-byte window while
    // ack is low. ack is a one-cycle pulse on the following cycle; the write
    // lands on the edge that raises ack, and read data is non-zero only with ack.
    always_comb begin
        off      = wbs_adr_i[7:0];
        hit      = (wbs_adr_i[31:8] == BASE_ADR[31:8]);
        req      = wbs_stb_i & wbs_cyc_i & hit & ~ack_q;
        wr_fire  = req & wbs_we_i;
        rd_fire  = req & ~wbs_we_i;
        wr_mask  = byte_mask(wbs_sel_i);
        duty_hit = '0;
        for (int i = 0; i < NCH; i++) begin
            duty_hit[i] = (off == OFF_DUTY0 + 8'(DUTY_STRIDE * i));
        end
    end

    always_comb begin
        ctrl_d     = ctrl_q;
        period_d   = period_q;
        prescale_d = prescale_q;
        pol_d      = pol_q;
        pf_d       = pf_q;
        if (wr_fire) begin
            case (off)
                OFF_CTRL:     ctrl_d     = (ctrl_q & ~wr_mask[2:0]) | (wbs_dat_i[2:0] & wr_mask[2:0]);
                OFF_PERIOD:   period_d   = (period_q & ~wr_mask[CW-1:0]) | (wbs_dat_i[CW-1:0] & wr_mask[CW-1:0]);
                OFF_PRESCALE: prescale_d = (prescale_q & ~wr_mask[7:0]) | (wbs_dat_i[7:0] & wr_mask[7:0]);
                OFF_STATUS:   if (wr_mask[0] && wbs_dat_i[0]) pf_d = 1'b0;
                OFF_POL:      pol_d      = (pol_q & ~wr_mask[NCH-1:0]) | (wbs_dat_i[NCH-1:0] & wr_mask[NCH-1:0]);
                default:      ;
            endcase
        end
        // A boundary in the same cycle as a clear keeps the flag set.
        if (boundary) begin
            pf_d = 1'b1;
        end
        irq_d = pf_d & ie;

        rdata = '0;
        case (off)
            OFF_CTRL:     rdata = 32'(ctrl_q);
            OFF_PERIOD:   rdata = 32'(period_q);
            OFF_PRESCALE: rdata = 32'(prescale_q);
            OFF_STATUS:   rdata = 32'(pf_q);
            OFF_POL:      rdata = 32'(pol_q);
            default: begin
                for (int i = 0; i < NCH; i++) begin
                    if (duty_hit[i]) rdata = 32'(duty_sh[i]);
                end
            end
        endcase
        ack_d = req;
        dat_d = rd_fire ? rdata : '0;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ctrl_q     <= '0;
            period_q   <= '0;
            prescale_q <= '0;
            pol_q      <= '0;
            pf_q       <= 1'b0;
            irq_q      <= 1'b0;
            ack_q      <= 1'b0;
            dat_q      <= '0;
        end else begin
            ctrl_q     <= ctrl_d;
            period_q   <= period_d;
            prescale_q <= prescale_d;
            pol_q      <= pol_d;
            pf_q       <= pf_d;
            irq_q      <= irq_d;
            ack_q      <= ack_d;
            dat_q      <= dat_d;
        end
    end

    // Counter FSM: state register.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            pcnt_q       <= '0;
            cnt_q        <= '0;
            period_act_q <= '0;
            dir_q        <= DIR_UP;
        end else begin
            pcnt_q       <= pcnt_d;
            cnt_q        <= cnt_d;
            period_act_q <= period_act_d;
            dir_q        <= dir_d;
        end
    end

    // Counter FSM: next state. Edge mode wraps at the period; center mode
    // turns around at the period and ends its period on the 1->0 step.
    always_comb begin
        tick         = en & (pcnt_q == prescale_q);
        boundary     = 1'b0;
        pcnt_d       = pcnt_q;
        cnt_d        = cnt_q;
        dir_d        = dir_q;
        period_act_d = period_act_q;
        if (!en) begin
            pcnt_d       = '0;
            cnt_d        = '0;
            dir_d        = DIR_UP;
            period_act_d = period_q;
        end else begin
            pcnt_d = tick ? 8'd0 : pcnt_q + 8'd1;
            if (tick) begin
                if (!center) begin
                    if (cnt_q >= period_act_q) begin
                        cnt_d    = '0;
                        boundary = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else if (period_act_q == '0) begin
                    cnt_d    = '0;
                    dir_d    = DIR_UP;
                    boundary = 1'b1;
                end else if (dir_q == DIR_UP) begin
                    if (cnt_q >= period_act_q) begin
                        dir_d = DIR_DOWN;
                        cnt_d = cnt_q - CNT_ONE;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else begin
                    if (cnt_q == CNT_ONE) begin
                        cnt_d    = '0;
                        dir_d    = DIR_UP;
                        boundary = 1'b1;
                    end else if (cnt_q == '0) begin
                        cnt_d = CNT_ONE;
                        dir_d = DIR_UP;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
            end
            if (boundary) begin
                period_act_d = period_q;
            end
        end
    end

    // Counter FSM: outputs.
    always_comb begin
        load_act = ~en | boundary;
        pwm_oeb  = {NCH{~en}};
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        pwm_channel #(.CW(CW)) u_ch (
            .clk         (wb_clk_i),
            .rst         (wb_rst_i),
            .en          (en),
            .load_act    (load_act),
            .wr_en       (wr_fire & duty_hit[g]),
            .wr_mask     (wr_mask[CW-1:0]),
            .wr_data     (wbs_dat_i[CW-1:0]),
            .cnt         (cnt_q),
            .pol         (pol_q[g]),
            .duty_shadow (duty_sh[g]),
            .pwm         (pwm_o[g])
        );
    end

    // Data and mask bits above the widest field have no destination.
    assign unused_bits = ^{wbs_dat_i, wr_mask};

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign irq_o     = irq_q;

endmodule

// File: tb/tb_user_proj_pwm_multi.sv
// Directed self-checking bench for user_proj_pwm_multi: edge/center waveforms,
// shadowed updates, limits/polarity, interrupt, bus rules and reset.
module tb_user_proj_pwm_multi;

    localparam int          NCH  = 8;
    localparam int          CW   = 16;
    localparam logic [31:0] BASE = 32'h3000_0000;

    localparam logic [7:0] A_CTRL     = 8'h00;
    localparam logic [7:0] A_PERIOD   = 8'h04;
    localparam logic [7:0] A_PRESCALE = 8'h08;
    localparam logic [7:0] A_STATUS   = 8'h0C;
    localparam logic [7:0] A_POL      = 8'h10;
    localparam logic [7:0] A_DUTY0    = 8'h20;
    localparam logic [7:0] A_DUTY1    = 8'h24;
    localparam logic [7:0] A_DUTY2    = 8'h28;
    localparam logic [7:0] A_DUTY3    = 8'h2C;

    logic           clk = 1'b0;
    logic           rst;
    logic           stb, cyc, we;
    logic [3:0]     sel;
    logic [31:0]    dat_i, adr;
    logic           ack;
    logic [31:0]    dat_o;
    logic [NCH-1:0] pwm_o, pwm_oeb;
    logic           irq;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    user_proj_pwm_multi #(.NCH(NCH), .CW(CW), .BASE_ADR(BASE)) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .wbs_stb_i (stb),
        .wbs_cyc_i (cyc),
        .wbs_we_i  (we),
        .wbs_sel_i (sel),
        .wbs_dat_i (dat_i),
        .wbs_adr_i (adr),
        .wbs_ack_o (ack),
        .wbs_dat_o (dat_o),
        .pwm_o     (pwm_o),
        .pwm_oeb   (pwm_oeb),
        .irq_o     (irq)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drives one access starting on the next cycle; returns #1 after the ack edge.
    task automatic wb_access(input logic w, input logic [7:0] off, input logic [31:0] d,
                             input logic [3:0] s, output logic [31:0] rd, output int lat);
        @(posedge clk); #1;
        stb = 1'b1; cyc = 1'b1; we = w; adr = BASE | 32'(off); dat_i = d; sel = s;
        lat = 0;
        rd  = '0;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk); #1;
            if (ack) begin
                lat = i;
                rd  = dat_o;
                break;
            end
        end
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        if (lat == 0) check_eq("ack_timeout", 32'(ack), 32'h1);
    endtask

    task automatic wb_write(input logic [7:0] off, input logic [31:0] d, input logic [3:0] s = 4'hF);
        logic [31:0] rd;
        int lat;
        wb_access(1'b1, off, d, s, rd, lat);
    endtask

    task automatic rd_check(input string tag, input logic [7:0] off, input logic [31:0] exp);
        logic [31:0] rd;
        int lat;
        exp_q.push_back(exp);
        wb_access(1'b0, off, 32'h0, 4'hF, rd, lat);
        check_eq(tag, rd, exp_q.pop_front());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        int lat;
        int m, c, d;

        rst = 1'b1; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0; dat_i = '0; adr = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_pwm", 32'(pwm_o), 32'h0);
        check_eq("rst_oeb", 32'(pwm_oeb), 32'hFF);
        check_eq("rst_irq", 32'(irq), 32'h0);
        check_eq("rst_ack", 32'(ack), 32'h0);
        check_eq("rst_dat", dat_o, 32'h0);
        rst = 1'b0;

        // Setup while disabled: outputs show polarity only.
        wb_write(A_PERIOD, 32'd9);
        wb_write(A_DUTY0, 32'd3);
        wb_write(A_DUTY2, 32'd0);
        wb_write(A_DUTY3, 32'd15);
        wb_write(A_POL, 32'h4);
        @(posedge clk); #1;
        check_eq("dis_pwm_pol", 32'(pwm_o), 32'h4);
        check_eq("dis_oeb", 32'(pwm_oeb), 32'hFF);

        // Edge mode: cycle 0 is the first with EN=1; pwm lags cnt by one cycle.
        wb_write(A_CTRL, 32'h1);
        for (int k = 1; k <= 20; k++) exp_q.push_back(32'(((k - 1) % 10) < 3));
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            check_eq("edge_ch0", 32'(pwm_o[0]), exp_q.pop_front());
            check_eq("limits_ch2_ch3", 32'(pwm_o[3:2]), 32'h3);
        end
        check_eq("edge_oeb", 32'(pwm_oeb), 32'h0);

        // Shadow update at cycle 22 (cnt=2); new duty only from the wrap at cycle 30.
        wb_write(A_DUTY0, 32'd7);
        for (c = 23; c <= 45; c++) begin
            d = ((c - 1) >= 30) ? 7 : 3;
            exp_q.push_back(32'(((c - 1) % 10) < d));
        end
        for (c = 23; c <= 45; c++) begin
            @(posedge clk); #1;
            check_eq("shadow_ch0", 32'(pwm_o[0]), exp_q.pop_front());
        end

        // Center mode: cnt 0,1,2,3,4,3,2,1 repeating.
        wb_write(A_CTRL, 32'h0);
        wb_write(A_PERIOD, 32'd4);
        wb_write(A_DUTY1, 32'd2);
        wb_write(A_CTRL, 32'h3);
        for (int k = 1; k <= 17; k++) begin
            m = (k - 1) % 8;
            exp_q.push_back(32'(((m <= 4) ? m : 8 - m) < 2));
        end
        for (int k = 1; k <= 17; k++) begin
            @(posedge clk); #1;
            check_eq("center_ch1", 32'(pwm_o[1]), exp_q.pop_front());
        end

        // Interrupt: tick every 2 cycles, 4 ticks per period -> PF at cycle 8.
        wb_write(A_CTRL, 32'h0);
        wb_write(A_PRESCALE, 32'd1);
        wb_write(A_PERIOD, 32'd3);
        wb_write(A_STATUS, 32'h1);
        rd_check("pf_cleared", A_STATUS, 32'h0);
        check_eq("irq_idle", 32'(irq), 32'h0);
        wb_write(A_CTRL, 32'h5);
        repeat (7) begin @(posedge clk); #1; end
        check_eq("irq_before", 32'(irq), 32'h0);
        @(posedge clk); #1;
        check_eq("irq_rise", 32'(irq), 32'h1);
        repeat (6) begin @(posedge clk); #1; end
        wb_write(A_STATUS, 32'h1);
        rd_check("pf_set_wins", A_STATUS, 32'h1);
        check_eq("irq_held", 32'(irq), 32'h1);
        wb_write(A_STATUS, 32'h1);
        check_eq("irq_cleared", 32'(irq), 32'h0);
        rd_check("pf_w1c", A_STATUS, 32'h0);

        // Bus rules.
        wb_access(1'b0, 8'h1C, 32'h0, 4'hF, rd, lat);
        check_eq("unmapped_lat", 32'(lat), 32'd1);
        check_eq("unmapped_dat", rd, 32'h0);
        @(posedge clk); #1;
        check_eq("ack_pulse", 32'(ack), 32'h0);
        check_eq("dat_idle", dat_o, 32'h0);
        wb_write(A_PERIOD, 32'h0000_1234, 4'b0010);
        rd_check("period_bytesel", A_PERIOD, 32'h0000_1203);
        wb_write(A_POL, 32'hFFFF_FFFF);
        rd_check("pol_width", A_POL, 32'h0000_00FF);
        wb_write(8'h1C, 32'hFFFF_FFFF);
        wb_write(8'h40, 32'h55);
        rd_check("dut_beyond_nch", 8'h40, 32'h0);
        rd_check("ctrl_after_unmapped", A_CTRL, 32'h5);
        rd_check("duty0_rb", A_DUTY0, 32'd7);
        rd_check("duty3_rb", A_DUTY3, 32'd15);

        // Reset while running with a write in flight.
        @(posedge clk); #1;
        rst = 1'b1; stb = 1'b1; cyc = 1'b1; we = 1'b1;
        adr = BASE | 32'(A_CTRL); dat_i = 32'h3; sel = 4'hF;
        @(posedge clk); #1;
        check_eq("mid_rst_pwm", 32'(pwm_o), 32'h0);
        check_eq("mid_rst_oeb", 32'(pwm_oeb), 32'hFF);
        check_eq("mid_rst_irq", 32'(irq), 32'h0);
        check_eq("mid_rst_ack", 32'(ack), 32'h0);
        rst = 1'b0; stb = 1'b0; cyc = 1'b0; we = 1'b0;
        rd_check("rst_ctrl", A_CTRL, 32'h0);
        rd_check("rst_period", A_PERIOD, 32'h0);
        rd_check("rst_prescale", A_PRESCALE, 32'h0);
        rd_check("rst_pol", A_POL, 32'h0);
        rd_check("rst_duty0", A_DUTY0, 32'h0);
        rd_check("rst_status", A_STATUS, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
